// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY/LTSSM definitions: TS ordered-set symbols, lane FSM states, TS field record.
package pcie_phy_pkg;

    localparam logic [7:0] COM_K  = 8'hBC;
    localparam logic [7:0] PAD_K  = 8'hF7;
    localparam logic [7:0] TS1_ID = 8'h4A;
    localparam logic [7:0] TS2_ID = 8'h45;

    localparam int unsigned TS_LEN    = 16;
    localparam logic [2:0]  RATE_GEN2 = 3'd1;

    typedef enum logic {
        ST_HUNT,
        ST_COLLECT
    } ts_rx_st_e;

    typedef struct packed {
        logic       is_ts2;
        logic [7:0] link;
        logic [7:0] lane;
        logic       link_pad;
        logic       lane_pad;
        logic [7:0] nfts;
        logic [7:0] rate_id;
        logic [7:0] train_ctrl;
    } ts_fields_t;

endpackage

// File: rtl/ltssm_ts_rx_lane.sv
// One lane of the TS1/TS2 receive qualifier: symbol FSM, field capture, consecutive counter.
// Optional malformed-TS counter under LTSSM_TS_RX_ERR_CNT_EN.
module ltssm_ts_rx_lane
    import pcie_phy_pkg::*;
#(
    parameter int unsigned CONSEC_TARGET = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       abort_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_datak_i,
    input  logic       rx_valid_i,
    output logic       ts_valid_o,
    output logic       is_ts2_o,
    output logic [7:0] link_o,
    output logic [7:0] lane_o,
    output logic       link_pad_o,
    output logic       lane_pad_o,
    output logic [7:0] rate_id_o,
    output logic [7:0] train_ctrl_o,
    output logic       consec_ok_o,
    output logic       consec_ok_nxt_o
`ifdef LTSSM_TS_RX_ERR_CNT_EN
    ,
    output logic [7:0] err_cnt_o
`endif
);

    localparam logic [3:0] TGT = 4'(CONSEC_TARGET);

    ts_rx_st_e  r_state, w_state_nxt;
    logic [3:0] r_idx, w_idx_nxt;
    ts_fields_t r_wrk, w_wrk_nxt;
    ts_fields_t r_fields, w_fields_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic       r_ts_valid, w_ts_valid_nxt;
    logic       r_ok, w_ok_nxt;
    logic       w_bad, w_sym_ok, w_com;

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_wrk_nxt      = r_wrk;
        w_fields_nxt   = r_fields;
        w_cnt_nxt      = r_cnt;
        w_ts_valid_nxt = 1'b0;
        w_bad          = 1'b0;
        w_sym_ok       = 1'b0;
        w_com          = rx_datak_i && (rx_data_i == COM_K);

        if (rx_valid_i) begin
            case (r_state)
                ST_HUNT: begin
                    if (w_com) begin
                        w_state_nxt = ST_COLLECT;
                        w_idx_nxt   = 4'd1;
                    end
                end
                ST_COLLECT: begin
                    // A COM mid-TS is an error but also the start of the next TS
                    if (w_com) begin
                        w_bad     = 1'b1;
                        w_idx_nxt = 4'd1;
                    end else begin
                        case (r_idx)
                            4'd1: begin
                                w_sym_ok           = !rx_datak_i || (rx_data_i == PAD_K);
                                w_wrk_nxt.link     = rx_data_i;
                                w_wrk_nxt.link_pad = rx_datak_i;
                            end
                            4'd2: begin
                                w_sym_ok           = !rx_datak_i || (rx_data_i == PAD_K);
                                w_wrk_nxt.lane     = rx_data_i;
                                w_wrk_nxt.lane_pad = rx_datak_i;
                            end
                            4'd3: begin
                                w_sym_ok       = !rx_datak_i;
                                w_wrk_nxt.nfts = rx_data_i;
                            end
                            4'd4: begin
                                w_sym_ok          = !rx_datak_i;
                                w_wrk_nxt.rate_id = rx_data_i;
                            end
                            4'd5: begin
                                w_sym_ok             = !rx_datak_i;
                                w_wrk_nxt.train_ctrl = rx_data_i;
                            end
                            4'd6: begin
                                w_sym_ok         = !rx_datak_i &&
                                                   (rx_data_i == TS1_ID || rx_data_i == TS2_ID);
                                w_wrk_nxt.is_ts2 = (rx_data_i == TS2_ID);
                            end
                            default: begin
                                w_sym_ok = !rx_datak_i &&
                                           (rx_data_i == (r_wrk.is_ts2 ? TS2_ID : TS1_ID));
                            end
                        endcase

                        if (!w_sym_ok) begin
                            w_bad       = 1'b1;
                            w_state_nxt = ST_HUNT;
                            w_idx_nxt   = '0;
                        end else if (r_idx == 4'(TS_LEN - 1)) begin
                            w_state_nxt    = ST_HUNT;
                            w_idx_nxt      = '0;
                            w_ts_valid_nxt = 1'b1;
                            w_fields_nxt   = w_wrk_nxt;
                            if (w_wrk_nxt == r_fields)
                                w_cnt_nxt = (r_cnt >= TGT) ? TGT : r_cnt + 4'd1;
                            else
                                w_cnt_nxt = 4'd1;
                        end else begin
                            w_idx_nxt = r_idx + 4'd1;
                        end
                    end
                end
                default: w_state_nxt = ST_HUNT;
            endcase
        end

        if (w_bad)
            w_cnt_nxt = '0;
        if (clr_i || abort_i) begin
            w_state_nxt    = ST_HUNT;
            w_idx_nxt      = '0;
            w_cnt_nxt      = '0;
            w_ts_valid_nxt = 1'b0;
        end
        if (clr_i)
            w_fields_nxt = '0;
        w_ok_nxt = (w_cnt_nxt >= TGT);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_HUNT;
            r_idx      <= '0;
            r_wrk      <= '0;
            r_fields   <= '0;
            r_cnt      <= '0;
            r_ts_valid <= 1'b0;
            r_ok       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_wrk      <= w_wrk_nxt;
            r_fields   <= w_fields_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ts_valid <= w_ts_valid_nxt;
            r_ok       <= w_ok_nxt;
        end
    end

`ifdef LTSSM_TS_RX_ERR_CNT_EN
    logic [7:0] r_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_err <= '0;
        else if (clr_i)
            r_err <= '0;
        else if (w_bad && (r_err != 8'hFF))
            r_err <= r_err + 8'd1;
    end

    assign err_cnt_o = r_err;
`endif

    assign ts_valid_o      = r_ts_valid;
    assign is_ts2_o        = r_fields.is_ts2;
    assign link_o          = r_fields.link;
    assign lane_o          = r_fields.lane;
    assign link_pad_o      = r_fields.link_pad;
    assign lane_pad_o      = r_fields.lane_pad;
    assign rate_id_o       = r_fields.rate_id;
    assign train_ctrl_o    = r_fields.train_ctrl;
    assign consec_ok_o     = r_ok;
    assign consec_ok_nxt_o = w_ok_nxt;

endmodule

// File: rtl/ltssm_ts_rx_monitor.sv
// Multi-lane PCIe TS1/TS2 receive monitor (Gen1/Gen2) with aggregate consecutive-TS flag.
// Define LTSSM_TS_RX_ERR_CNT_EN to add the per-lane malformed-TS counter output err_cnt_o.
module ltssm_ts_rx_monitor
    import pcie_phy_pkg::*;
#(
    parameter int unsigned MAX_NUM_LANES = 4,
    parameter int unsigned CONSEC_TARGET = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       en_i,
    input  logic [2:0]                 phy_rate_i,
    input  logic [MAX_NUM_LANES-1:0]   lane_mask_i,
    input  logic [8*MAX_NUM_LANES-1:0] rx_data_i,
    input  logic [MAX_NUM_LANES-1:0]   rx_datak_i,
    input  logic [MAX_NUM_LANES-1:0]   rx_valid_i,
    output logic [MAX_NUM_LANES-1:0]   ts_valid_o,
    output logic [MAX_NUM_LANES-1:0]   ts_is_ts2_o,
    output logic [8*MAX_NUM_LANES-1:0] link_num_o,
    output logic [8*MAX_NUM_LANES-1:0] lane_num_o,
    output logic [MAX_NUM_LANES-1:0]   link_pad_o,
    output logic [MAX_NUM_LANES-1:0]   lane_pad_o,
    output logic [8*MAX_NUM_LANES-1:0] rate_id_o,
    output logic [8*MAX_NUM_LANES-1:0] train_ctrl_o,
    output logic [MAX_NUM_LANES-1:0]   lane_consec_ok_o,
    output logic                       all_consec_ok_o
`ifdef LTSSM_TS_RX_ERR_CNT_EN
    ,
    output logic [8*MAX_NUM_LANES-1:0] err_cnt_o
`endif
);

    logic [2:0]               r_rate;
    logic                     r_all_ok;
    logic                     w_clr, w_abort;
    logic [MAX_NUM_LANES-1:0] w_ok_nxt;

    // Unsupported rates (128b/130b) behave exactly like a disabled monitor
    assign w_clr   = !en_i || (phy_rate_i > RATE_GEN2);
    assign w_abort = (phy_rate_i != r_rate);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rate   <= '0;
            r_all_ok <= 1'b0;
        end else begin
            r_rate   <= phy_rate_i;
            r_all_ok <= (lane_mask_i != '0) && (&(w_ok_nxt | ~lane_mask_i));
        end
    end

    assign all_consec_ok_o = r_all_ok;

    for (genvar g = 0; g < MAX_NUM_LANES; g++) begin : g_lane
        ltssm_ts_rx_lane #(
            .CONSEC_TARGET (CONSEC_TARGET)
        ) u_lane (
            .clk_i           (clk_i),
            .rst_ni          (rst_ni),
            .clr_i           (w_clr),
            .abort_i         (w_abort),
            .rx_data_i       (rx_data_i[g*8 +: 8]),
            .rx_datak_i      (rx_datak_i[g]),
            .rx_valid_i      (rx_valid_i[g]),
            .ts_valid_o      (ts_valid_o[g]),
            .is_ts2_o        (ts_is_ts2_o[g]),
            .link_o          (link_num_o[g*8 +: 8]),
            .lane_o          (lane_num_o[g*8 +: 8]),
            .link_pad_o      (link_pad_o[g]),
            .lane_pad_o      (lane_pad_o[g]),
            .rate_id_o       (rate_id_o[g*8 +: 8]),
            .train_ctrl_o    (train_ctrl_o[g*8 +: 8]),
            .consec_ok_o     (lane_consec_ok_o[g]),
            .consec_ok_nxt_o (w_ok_nxt[g])
`ifdef LTSSM_TS_RX_ERR_CNT_EN
            ,
            .err_cnt_o       (err_cnt_o[g*8 +: 8])
`endif
        );
    end

endmodule

// File: tb/tb_ltssm_ts_rx_monitor.sv
// Self-checking bench for ltssm_ts_rx_monitor: directed scenarios plus randomized TS streams
// checked against a TS-level reference model (also covers LTSSM_TS_RX_ERR_CNT_EN when defined).
module tb_ltssm_ts_rx_monitor;

    localparam int N   = 4;
    localparam int TGT = 8;
    localparam int AW  = 37 * N + 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic [2:0]     phy_rate;
    logic [N-1:0]   lane_mask;
    logic [8*N-1:0] rx_data;
    logic [N-1:0]   rx_datak;
    logic [N-1:0]   rx_valid;
    logic [N-1:0]   ts_valid_o, ts_is_ts2_o, link_pad_o, lane_pad_o, lane_consec_ok_o;
    logic [8*N-1:0] link_num_o, lane_num_o, rate_id_o, train_ctrl_o;
    logic           all_consec_ok_o;
`ifdef LTSSM_TS_RX_ERR_CNT_EN
    logic [8*N-1:0] err_cnt_o;
`endif

    always #5 clk = ~clk;

    ltssm_ts_rx_monitor #(
        .MAX_NUM_LANES (N),
        .CONSEC_TARGET (TGT)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .en_i             (en),
        .phy_rate_i       (phy_rate),
        .lane_mask_i      (lane_mask),
        .rx_data_i        (rx_data),
        .rx_datak_i       (rx_datak),
        .rx_valid_i       (rx_valid),
        .ts_valid_o       (ts_valid_o),
        .ts_is_ts2_o      (ts_is_ts2_o),
        .link_num_o       (link_num_o),
        .lane_num_o       (lane_num_o),
        .link_pad_o       (link_pad_o),
        .lane_pad_o       (lane_pad_o),
        .rate_id_o        (rate_id_o),
        .train_ctrl_o     (train_ctrl_o),
        .lane_consec_ok_o (lane_consec_ok_o),
        .all_consec_ok_o  (all_consec_ok_o)
`ifdef LTSSM_TS_RX_ERR_CNT_EN
        ,
        .err_cnt_o        (err_cnt_o)
`endif
    );

    typedef struct packed {
        logic       ts2;
        logic [7:0] link;
        logic [7:0] lane;
        logic       lpad;
        logic       npad;
        logic [7:0] nfts;
        logic [7:0] rate;
        logic [7:0] train;
    } fld_t;

    // Reference model state, one entry per lane
    fld_t m_f   [N];
    bit   m_have[N];
    int   m_cnt [N];
    int   m_err [N];

    logic [7:0] ts_s[16];
    logic       ts_k[16];

    int n_tests = 0;
    int n_fail  = 0;

    logic [AW-1:0] all_out;
    assign all_out = {ts_valid_o, ts_is_ts2_o, link_num_o, lane_num_o, link_pad_o, lane_pad_o,
                      rate_id_o, train_ctrl_o, lane_consec_ok_o, all_consec_ok_o};

    function automatic bit ts_ok();
        if (!(ts_k[0] && ts_s[0] == 8'hBC)) return 1'b0;
        for (int i = 1; i <= 2; i++) if (ts_k[i] && ts_s[i] != 8'hF7) return 1'b0;
        for (int i = 3; i <= 5; i++) if (ts_k[i]) return 1'b0;
        if (ts_k[6] || (ts_s[6] != 8'h4A && ts_s[6] != 8'h45)) return 1'b0;
        for (int i = 7; i <= 15; i++) if (ts_k[i] || ts_s[i] != ts_s[6]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic fld_t ts_fields();
        fld_t f;
        f.ts2   = (ts_s[6] == 8'h45);
        f.link  = ts_s[1];
        f.lpad  = ts_k[1];
        f.lane  = ts_s[2];
        f.npad  = ts_k[2];
        f.nfts  = ts_s[3];
        f.rate  = ts_s[4];
        f.train = ts_s[5];
        return f;
    endfunction

    function automatic fld_t rand_fields();
        fld_t f;
        f.ts2   = 1'($urandom_range(0, 1));
        f.lpad  = ($urandom_range(0, 3) == 0);
        f.link  = f.lpad ? 8'hF7 : 8'($urandom);
        f.npad  = ($urandom_range(0, 3) == 0);
        f.lane  = f.npad ? 8'hF7 : 8'($urandom);
        f.nfts  = 8'($urandom);
        f.rate  = 8'($urandom);
        f.train = 8'($urandom);
        return f;
    endfunction

    function automatic logic [34:0] vis(input fld_t f);
        return {f.ts2, f.link, f.lane, f.lpad, f.npad, f.rate, f.train};
    endfunction

    function automatic logic [34:0] dut_vis(input int l);
        return {ts_is_ts2_o[l], link_num_o[l*8 +: 8], lane_num_o[l*8 +: 8], link_pad_o[l],
                lane_pad_o[l], rate_id_o[l*8 +: 8], train_ctrl_o[l*8 +: 8]};
    endfunction

    function automatic logic exp_all();
        if (lane_mask == '0) return 1'b0;
        for (int l = 0; l < N; l++)
            if (lane_mask[l] && m_cnt[l] < TGT) return 1'b0;
        return 1'b1;
    endfunction

    task automatic build_ts(input fld_t f);
        ts_s[0] = 8'hBC;  ts_k[0] = 1'b1;
        ts_s[1] = f.link; ts_k[1] = f.lpad;
        ts_s[2] = f.lane; ts_k[2] = f.npad;
        ts_s[3] = f.nfts; ts_k[3] = 1'b0;
        ts_s[4] = f.rate; ts_k[4] = 1'b0;
        ts_s[5] = f.train; ts_k[5] = 1'b0;
        for (int i = 6; i < 16; i++) begin
            ts_s[i] = f.ts2 ? 8'h45 : 8'h4A;
            ts_k[i] = 1'b0;
        end
    endtask

    task automatic corrupt();
        int p;
        p = $urandom_range(1, 15);
        if (p <= 2) begin
            ts_s[p] = 8'h1C; ts_k[p] = 1'b1;
        end else if (p <= 5) begin
            ts_s[p] = 8'h1C; ts_k[p] = 1'b1;
        end else if (p == 6) begin
            ts_s[6] = 8'($urandom_range(0, 63));
        end else begin
            ts_s[p] = ts_s[p] ^ 8'h0F;
        end
    endtask

    task automatic model_update(input int l, input bit good, input fld_t f);
        if (good) begin
            if (m_have[l] && f == m_f[l]) m_cnt[l] = (m_cnt[l] + 1 > TGT) ? TGT : m_cnt[l] + 1;
            else                          m_cnt[l] = 1;
            m_f[l]    = f;
            m_have[l] = 1'b1;
        end else begin
            m_cnt[l] = 0;
            m_err[l] = (m_err[l] >= 255) ? 255 : m_err[l] + 1;
        end
    endtask

    task automatic model_clear();
        for (int l = 0; l < N; l++) begin
            m_f[l] = '0; m_have[l] = 1'b0; m_cnt[l] = 0; m_err[l] = 0;
        end
    endtask

    task automatic drive_sym(input logic [N-1:0] lanes, input logic [7:0] s, input logic k);
        @(negedge clk);
        for (int l = 0; l < N; l++)
            if (lanes[l]) begin
                rx_data[l*8 +: 8] = s;
                rx_datak[l]       = k;
            end
        rx_valid = lanes;
        @(posedge clk); #1;
        rx_valid = '0;
    endtask

    task automatic gap_cycle();
        @(negedge clk);
        rx_data  = $urandom;
        rx_datak = '1;
        rx_valid = '0;
        @(posedge clk); #1;
    endtask

    // gaps: 0 none, 1 idle cycle before every symbol, 2 random idle cycles
    task automatic send_ts(input logic [N-1:0] lanes, input int gaps);
        bit   good;
        fld_t f;
        int   spur;
        good = ts_ok();
        f    = ts_fields();
        spur = 0;
        for (int i = 0; i < 16; i++) begin
            if (gaps == 1 || (gaps == 2 && $urandom_range(0, 1) == 1)) begin
                gap_cycle();
                spur += int'(|(ts_valid_o & lanes));
            end
            drive_sym(lanes, ts_s[i], ts_k[i]);
            if (i < 15) spur += int'(|(ts_valid_o & lanes));
        end
        n_tests++;
        if (spur != 0) begin
            n_fail++;
            $display("FAIL ts_valid_early: got %0d pulses before symbol 15, expected 0", spur);
        end
        for (int l = 0; l < N; l++) begin
            if (!lanes[l]) continue;
            model_update(l, good, f);
            n_tests++;
            if (ts_valid_o[l] !== good) begin
                n_fail++;
                $display("FAIL ts_valid lane%0d: got %b expected %b", l, ts_valid_o[l], good);
            end
            n_tests++;
            if (dut_vis(l) !== vis(m_f[l])) begin
                n_fail++;
                $display("FAIL fields lane%0d: got %h expected %h", l, dut_vis(l), vis(m_f[l]));
            end
            n_tests++;
            if (lane_consec_ok_o[l] !== (m_cnt[l] >= TGT)) begin
                n_fail++;
                $display("FAIL consec_ok lane%0d: got %b expected %b (model count %0d)",
                         l, lane_consec_ok_o[l], (m_cnt[l] >= TGT), m_cnt[l]);
            end
`ifdef LTSSM_TS_RX_ERR_CNT_EN
            n_tests++;
            if (err_cnt_o[l*8 +: 8] !== 8'(m_err[l])) begin
                n_fail++;
                $display("FAIL err_cnt lane%0d: got %0d expected %0d", l, err_cnt_o[l*8 +: 8], m_err[l]);
            end
`endif
        end
        n_tests++;
        if (all_consec_ok_o !== exp_all()) begin
            n_fail++;
            $display("FAIL all_consec_ok: got %b expected %b", all_consec_ok_o, exp_all());
        end
    endtask

    task automatic check_all_zero(input string name);
        n_tests++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL %s: got %h expected all zero", name, all_out);
        end
`ifdef LTSSM_TS_RX_ERR_CNT_EN
        n_tests++;
        if (err_cnt_o !== '0) begin
            n_fail++;
            $display("FAIL %s_err: got %h expected 0", name, err_cnt_o);
        end
`endif
    endtask

    task automatic clear_en();
        @(negedge clk);
        en       = 1'b0;
        rx_valid = '0;
        @(posedge clk); #1;
        model_clear();
        check_all_zero("en_clear");
        en = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; phy_rate = 3'd0; lane_mask = '1;
        rx_data = '0; rx_datak = '0; rx_valid = '0;
        model_clear();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ts1_train();
        fld_t f;
        clear_en();
        f = '{ts2: 1'b0, link: 8'hF7, lane: 8'hF7, lpad: 1'b1, npad: 1'b1,
              nfts: 8'h20, rate: 8'h02, train: 8'h00};
        build_ts(f);
        repeat (8) send_ts(4'b0001, 0);
    endtask

    task automatic test_type_change();
        fld_t f;
        clear_en();
        f = '{ts2: 1'b0, link: 8'hF7, lane: 8'hF7, lpad: 1'b1, npad: 1'b1,
              nfts: 8'h20, rate: 8'h02, train: 8'h00};
        build_ts(f);
        repeat (4) send_ts(4'b0001, 0);
        f.ts2 = 1'b1;
        build_ts(f);
        repeat (9) send_ts(4'b0001, 0);
    endtask

    task automatic test_bad_symbol();
        fld_t f;
        clear_en();
        f = '{ts2: 1'b0, link: 8'h05, lane: 8'h01, lpad: 1'b0, npad: 1'b0,
              nfts: 8'h40, rate: 8'h02, train: 8'h00};
        build_ts(f);
        send_ts(4'b0001, 0);
        ts_s[9] = 8'h45;
        send_ts(4'b0001, 0);
        build_ts(f);
        repeat (8) send_ts(4'b0001, 0);
    endtask

    task automatic test_com_restart();
        int spur;
        clear_en();
        build_ts(rand_fields());
        spur = 0;
        for (int i = 0; i < 7; i++) begin
            drive_sym(4'b0001, ts_s[i], ts_k[i]);
            spur += int'(ts_valid_o[0]);
        end
        n_tests++;
        if (spur != 0) begin
            n_fail++;
            $display("FAIL partial_ts_valid: got %0d pulses expected 0", spur);
        end
        model_update(0, 1'b0, '0);
        build_ts(rand_fields());
        send_ts(4'b0001, 0);
    endtask

    task automatic test_gaps();
        clear_en();
        build_ts(rand_fields());
        repeat (3) send_ts(4'b0010, 1);
    endtask

    task automatic test_multilane();
        clear_en();
        lane_mask = 4'b0011;
        build_ts(rand_fields());
        repeat (8) send_ts(4'b0011, 0);
        clear_en();
        lane_mask = '1;
    endtask

    task automatic test_rate_change();
        clear_en();
        build_ts(rand_fields());
        repeat (8) send_ts(4'b0100, 0);
        @(negedge clk);
        phy_rate = 3'd1;
        @(posedge clk); #1;
        for (int l = 0; l < N; l++) m_cnt[l] = 0;
        n_tests++;
        if (lane_consec_ok_o[2] !== 1'b0 || dut_vis(2) !== vis(m_f[2])) begin
            n_fail++;
            $display("FAIL rate_abort: got ok=%b fields=%h expected ok=0 fields=%h",
                     lane_consec_ok_o[2], dut_vis(2), vis(m_f[2]));
        end
        send_ts(4'b0100, 0);
        @(negedge clk);
        phy_rate = 3'd2;
        @(posedge clk); #1;
        model_clear();
        check_all_zero("rate_unsupported");
        @(negedge clk);
        phy_rate = 3'd0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int   l;
        fld_t f;
        clear_en();
        for (int it = 0; it < 80; it++) begin
            l = $urandom_range(0, N - 1);
            if (m_have[l] && $urandom_range(0, 3) != 0) f = m_f[l];
            else                                         f = rand_fields();
            build_ts(f);
            if ($urandom_range(0, 4) == 0) corrupt();
            send_ts(N'(1) << l, ($urandom_range(0, 3) == 0) ? 2 : 0);
        end
    endtask

    initial begin
        test_reset();
        test_ts1_train();
        test_type_change();
        test_bad_symbol();
        test_com_restart();
        test_gaps();
        test_multilane();
        test_rate_change();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
